// File: rtl/mux8_arb_pkg.sv
// rtl/mux8_arb_pkg.sv - shared constants and types for the 8-way round-robin mux arbiter
package mux8_arb_pkg;
  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic {IDLE, FULL} arb_state_t;
  typedef logic [SEL_W-1:0] sel_t;
endpackage

// File: rtl/rr_pick8.sv
// rtl/rr_pick8.sv - combinational 8-way round-robin picker (rotate, priority encode, un-rotate)
module rr_pick8
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  sel_t             last,
  output logic [N_REQ-1:0] gnt_onehot,
  output sel_t             gnt_idx,
  output logic             any
);

  sel_t             base;
  sel_t             off;
  logic             found;
  logic [N_REQ-1:0] rot;

  // rot[0] is the requester just after the previous winner; sel_t arithmetic wraps 7->0
  always_comb begin
    base = last + sel_t'(1);
    rot  = '0;
    for (int j = 0; j < N_REQ; j++) begin
      rot[j] = req[base + sel_t'(j)];
    end
    off   = '0;
    found = 1'b0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && rot[j]) begin
        off   = sel_t'(j);
        found = 1'b1;
      end
    end
    any        = |req;
    gnt_idx    = base + off;
    gnt_onehot = any ? (N_REQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter feeding a registered 8:1 beat mux
// Optional burst locking via MUX8_ARB_LOCK_EN (adds in_last).
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        in_valid,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  output logic [N_REQ-1:0]        in_ready,
`ifdef MUX8_ARB_LOCK_EN
  input  logic [N_REQ-1:0]        in_last,
`endif
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  arb_state_t       state_q, state_d;
  sel_t             last_q;
  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] gnt_onehot;
  sel_t             gnt_idx;
  logic             any;
  logic             load;
  logic             xfer;
  logic [DATA_W-1:0] sel_data;

`ifdef MUX8_ARB_LOCK_EN
  logic lock_q;
  sel_t lock_idx_q;

  // while a burst is open only its owner is visible to the picker
  assign req_eff = lock_q ? (in_valid & (N_REQ'(1) << lock_idx_q)) : in_valid;
`else
  assign req_eff = in_valid;
`endif

  rr_pick8 u_pick (
    .req        (req_eff),
    .last       (last_q),
    .gnt_onehot (gnt_onehot),
    .gnt_idx    (gnt_idx),
    .any        (any)
  );

  assign out_valid = (state_q == FULL);
  assign load      = (state_q == IDLE) | (out_ready & out_valid);
  assign xfer      = load & any & ~rst;
  assign in_ready  = gnt_onehot & {N_REQ{xfer}};
  assign sel_data  = in_data[gnt_idx*DATA_W +: DATA_W];

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = FULL;
      FULL:    if (out_ready) state_d = xfer ? FULL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      out_data <= '0;
      out_sel  <= '0;
      last_q   <= sel_t'(N_REQ - 1);
`ifdef MUX8_ARB_LOCK_EN
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (xfer) begin
        out_data <= sel_data;
        out_sel  <= gnt_idx;
`ifdef MUX8_ARB_LOCK_EN
        // pointer only advances once the burst closes
        if (in_last[gnt_idx]) begin
          last_q <= gnt_idx;
          lock_q <= 1'b0;
        end else begin
          lock_q     <= 1'b1;
          lock_idx_q <= gnt_idx;
        end
`else
        last_q <= gnt_idx;
`endif
      end
    end
  end

endmodule
